role_udp_echo: RTL and testbench



---
 rtl/role_udp_echo.sv | 230 +++++++++++++++++++++++
 tb/tb_role_udp_echo.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/role_udp_echo.sv
// UDP echo role: stores one inbound payload in a local buffer, then replays it
// behind an outbound meta with swapped ports/ranks and the measured byte length.
module role_udp_echo #(
  parameter int          DATA_W       = 64,
  parameter int          DEPTH        = 256,
  parameter logic [15:0] LISTEN_PORT  = 16'h0A7A,
  parameter logic [15:0] ROLE_VERSION = 16'h0001
) (
  input  logic                  piSHL_156_25Clk,
  input  logic                  piSHL_156_25Rst_n,
  input  logic                  piMMIO_Ly7_Rst,
  input  logic                  piMMIO_Ly7_En,
  input  logic [DATA_W-1:0]     siNRC_Udp_Data_tdata,
  input  logic [DATA_W/8-1:0]   siNRC_Udp_Data_tkeep,
  input  logic                  siNRC_Udp_Data_tvalid,
  input  logic                  siNRC_Udp_Data_tlast,
  output logic                  siNRC_Udp_Data_tready,
  output logic [DATA_W-1:0]     soNRC_Udp_Data_tdata,
  output logic [DATA_W/8-1:0]   soNRC_Udp_Data_tkeep,
  output logic                  soNRC_Udp_Data_tvalid,
  output logic                  soNRC_Udp_Data_tlast,
  input  logic                  soNRC_Udp_Data_tready,
  input  logic [63:0]           siNRC_Role_Udp_Meta_TDATA,
  input  logic                  siNRC_Role_Udp_Meta_TVALID,
  output logic                  siNRC_Role_Udp_Meta_TREADY,
  output logic [63:0]           soROLE_Nrc_Udp_Meta_TDATA,
  output logic                  soROLE_Nrc_Udp_Meta_TVALID,
  input  logic                  soROLE_Nrc_Udp_Meta_TREADY,
  output logic [7:0]            soROLE_Nrc_Udp_Meta_TKEEP,
  output logic                  soROLE_Nrc_Udp_Meta_TLAST,
  output logic [31:0]           poROL_Nrc_Udp_Rx_ports,
  output logic [15:0]           poSHL_Mmio_RdReg,
  output logic [31:0]           poPktCnt,
  output logic [15:0]           poDropCnt,
  output logic [2:0]            poDbgState
);

  // All streams use AXI-style valid/ready: a beat transfers on a rising edge
  // where both are high; a source never drops valid or changes payload while
  // waiting, and no valid output depends combinationally on a ready input.

  localparam int KW = DATA_W / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int MW = DATA_W + KW + 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RX   = 3'd1,
    S_TXM  = 3'd2,
    S_TXD  = 3'd3,
    S_DROP = 3'd4
  } state_t;

  function automatic logic [15:0] popcount(input logic [KW-1:0] k);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < KW; i++) c = c + 16'(k[i]);
    return c;
  endfunction

  logic           clk;
  logic           rst_n;
  logic [1:0]     rst_sync_q;
  logic           run_ok;
  logic           clr;

  state_t         state_q, state_d;
  logic [63:0]    meta_q;
  logic [AW:0]    wr_cnt_q;
  logic [AW:0]    rd_cnt_q;
  logic [15:0]    byte_q, byte_d;
  logic [16:0]    byte_sum;
  logic [DATA_W-1:0] out_data_q;
  logic [KW-1:0]  out_keep_q;
  logic           out_last_q;
  logic           out_vld_q;
  logic [31:0]    pkt_q;
  logic [15:0]    drop_q;
  logic [MW-1:0]  mem [DEPTH];
  logic [MW-1:0]  rd_word;

  logic           meta_in_rdy, in_rdy, meta_out_vld;
  logic [63:0]    meta_out_data;
  logic           meta_in_hs, in_hs, out_hs, full, load_en, drop_evt, store_beat;
  logic           unused_len;

  assign clk   = piSHL_156_25Clk;
  assign rst_n = piSHL_156_25Rst_n;

  // Reset release is re-timed so nothing handshakes until two edges after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign run_ok = rst_sync_q[1];
  assign clr    = piMMIO_Ly7_Rst | ~run_ok;

  // The sender's length field is not trusted; the echoed length is measured.
  assign unused_len = ^siNRC_Role_Udp_Meta_TDATA[63:48];

  assign meta_in_hs = siNRC_Role_Udp_Meta_TVALID & meta_in_rdy;
  assign in_hs      = siNRC_Udp_Data_tvalid & in_rdy;
  assign out_hs     = out_vld_q & soNRC_Udp_Data_tready;
  assign full       = (wr_cnt_q == FULL_CNT);
  assign store_beat = (state_q == S_RX) & in_hs & ~full;
  assign drop_evt   = in_hs & siNRC_Udp_Data_tlast &
                      ((state_q == S_DROP) | ((state_q == S_RX) & full));

  // Output register is refilled in the same cycle it drains, so the buffer read
  // runs one beat ahead and back-to-back transfers sustain one beat per cycle.
  assign rd_word = mem[rd_cnt_q[AW-1:0]];
  assign load_en = ((state_q == S_TXM) & soROLE_Nrc_Udp_Meta_TREADY) |
                   ((state_q == S_TXD) & (~out_vld_q | soNRC_Udp_Data_tready) &
                    (rd_cnt_q != wr_cnt_q));

  assign byte_sum = {1'b0, byte_q} + {1'b0, popcount(siNRC_Udp_Data_tkeep)};
  assign byte_d   = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state_q <= S_IDLE;
    else if (clr) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (meta_in_hs) state_d = S_RX;
      S_RX: begin
        if (in_hs) begin
          if (full)                      state_d = siNRC_Udp_Data_tlast ? S_IDLE : S_DROP;
          else if (siNRC_Udp_Data_tlast) state_d = S_TXM;
        end
      end
      S_TXM:  if (soROLE_Nrc_Udp_Meta_TREADY) state_d = S_TXD;
      S_TXD:  if (out_hs && out_last_q) state_d = S_IDLE;
      S_DROP: if (in_hs && siNRC_Udp_Data_tlast) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    meta_in_rdy   = 1'b0;
    in_rdy        = 1'b0;
    meta_out_vld  = 1'b0;
    meta_out_data = '0;
    unique case (state_q)
      S_IDLE:        meta_in_rdy = piMMIO_Ly7_En & run_ok & ~piMMIO_Ly7_Rst;
      S_RX, S_DROP:  in_rdy      = run_ok & ~piMMIO_Ly7_Rst;
      S_TXM: begin
        meta_out_vld  = 1'b1;
        meta_out_data = {byte_q, meta_q[39:32], meta_q[47:40], meta_q[15:0], meta_q[31:16]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (store_beat)
      mem[wr_cnt_q[AW-1:0]] <= {siNRC_Udp_Data_tlast, siNRC_Udp_Data_tkeep, siNRC_Udp_Data_tdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q     <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      byte_q     <= '0;
      out_data_q <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
      pkt_q      <= '0;
      drop_q     <= '0;
    end else if (clr) begin
      meta_q     <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      byte_q     <= '0;
      out_data_q <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
      pkt_q      <= '0;
      drop_q     <= '0;
    end else begin
      if (meta_in_hs) begin
        meta_q   <= siNRC_Role_Udp_Meta_TDATA;
        wr_cnt_q <= '0;
        rd_cnt_q <= '0;
        byte_q   <= '0;
      end
      if (store_beat) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
        byte_q   <= byte_d;
      end
      if (load_en) begin
        out_data_q <= rd_word[DATA_W-1:0];
        out_keep_q <= rd_word[DATA_W +: KW];
        out_last_q <= rd_word[MW-1];
        out_vld_q  <= 1'b1;
        rd_cnt_q   <= rd_cnt_q + 1'b1;
      end else if (out_hs) begin
        out_vld_q <= 1'b0;
      end
      if (out_hs && out_last_q) pkt_q <= pkt_q + 1'b1;
      if (drop_evt && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
    end
  end

  assign siNRC_Udp_Data_tready      = in_rdy;
  assign siNRC_Role_Udp_Meta_TREADY = meta_in_rdy;
  assign soNRC_Udp_Data_tdata       = out_data_q;
  assign soNRC_Udp_Data_tkeep       = out_keep_q;
  assign soNRC_Udp_Data_tlast       = out_last_q;
  assign soNRC_Udp_Data_tvalid      = out_vld_q;
  assign soROLE_Nrc_Udp_Meta_TDATA  = meta_out_data;
  assign soROLE_Nrc_Udp_Meta_TVALID = meta_out_vld;
  assign soROLE_Nrc_Udp_Meta_TKEEP  = meta_out_vld ? 8'hFF : 8'h00;
  assign soROLE_Nrc_Udp_Meta_TLAST  = meta_out_vld;
  // A zero listen port is not a usable UDP port, so nothing is opened for it.
  assign poROL_Nrc_Udp_Rx_ports     = {31'd0, piMMIO_Ly7_En & (LISTEN_PORT != 16'h0000)};
  assign poSHL_Mmio_RdReg           = ROLE_VERSION;
  assign poPktCnt                   = pkt_q;
  assign poDropCnt                  = drop_q;
  assign poDbgState                 = state_q;

endmodule

// File: tb/tb_role_udp_echo.sv
// Directed bench for role_udp_echo: echo, zero-keep, backpressure, overflow
// drop, enable gating, soft reset and asynchronous reset mid-replay.
module tb_role_udp_echo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        soft_rst = 1'b0;
  logic        en = 1'b0;
  logic [63:0] di_tdata = '0;
  logic [7:0]  di_tkeep = '0;
  logic        di_tvalid = 1'b0;
  logic        di_tlast = 1'b0;
  logic        di_tready;
  logic [63:0] do_tdata;
  logic [7:0]  do_tkeep;
  logic        do_tvalid;
  logic        do_tlast;
  logic        do_tready = 1'b0;
  logic [63:0] mi_tdata = '0;
  logic        mi_tvalid = 1'b0;
  logic        mi_tready;
  logic [63:0] mo_tdata;
  logic        mo_tvalid;
  logic        mo_tready = 1'b0;
  logic [7:0]  mo_tkeep;
  logic        mo_tlast;
  logic [31:0] rx_ports;
  logic [15:0] rd_reg;
  logic [31:0] pkt_cnt;
  logic [15:0] drop_cnt;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_fail = 0;
  logic [63:0] pkt_d [16];
  logic [7:0]  pkt_k [16];

  always #5 clk = ~clk;

  role_udp_echo #(.DATA_W(64), .DEPTH(8), .LISTEN_PORT(16'h0A7A), .ROLE_VERSION(16'h0001)) dut (
    .piSHL_156_25Clk            (clk),
    .piSHL_156_25Rst_n          (rst_n),
    .piMMIO_Ly7_Rst             (soft_rst),
    .piMMIO_Ly7_En              (en),
    .siNRC_Udp_Data_tdata       (di_tdata),
    .siNRC_Udp_Data_tkeep       (di_tkeep),
    .siNRC_Udp_Data_tvalid      (di_tvalid),
    .siNRC_Udp_Data_tlast       (di_tlast),
    .siNRC_Udp_Data_tready      (di_tready),
    .soNRC_Udp_Data_tdata       (do_tdata),
    .soNRC_Udp_Data_tkeep       (do_tkeep),
    .soNRC_Udp_Data_tvalid      (do_tvalid),
    .soNRC_Udp_Data_tlast       (do_tlast),
    .soNRC_Udp_Data_tready      (do_tready),
    .siNRC_Role_Udp_Meta_TDATA  (mi_tdata),
    .siNRC_Role_Udp_Meta_TVALID (mi_tvalid),
    .siNRC_Role_Udp_Meta_TREADY (mi_tready),
    .soROLE_Nrc_Udp_Meta_TDATA  (mo_tdata),
    .soROLE_Nrc_Udp_Meta_TVALID (mo_tvalid),
    .soROLE_Nrc_Udp_Meta_TREADY (mo_tready),
    .soROLE_Nrc_Udp_Meta_TKEEP  (mo_tkeep),
    .soROLE_Nrc_Udp_Meta_TLAST  (mo_tlast),
    .poROL_Nrc_Udp_Rx_ports     (rx_ports),
    .poSHL_Mmio_RdReg           (rd_reg),
    .poPktCnt                   (pkt_cnt),
    .poDropCnt                  (drop_cnt),
    .poDbgState                 (dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_meta(input logic [63:0] m);
    int n = 0;
    mi_tdata = m;
    mi_tvalid = 1'b1;
    while (mi_tready !== 1'b1 && n < 40) begin tick(); n++; end
    chk("meta_in_ready", {63'd0, mi_tready}, 64'd1);
    tick();
    mi_tvalid = 1'b0;
    mi_tdata = '0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n = 0;
    di_tdata = d;
    di_tkeep = k;
    di_tlast = l;
    di_tvalid = 1'b1;
    while (di_tready !== 1'b1 && n < 40) begin tick(); n++; end
    chk("data_in_ready", {63'd0, di_tready}, 64'd1);
    tick();
    di_tvalid = 1'b0;
    di_tlast = 1'b0;
  endtask

  // Holds ready low for one cycle once valid shows, to see the meta held stable.
  task automatic recv_meta(input logic [63:0] exp);
    int n = 0;
    mo_tready = 1'b0;
    while (mo_tvalid !== 1'b1 && n < 40) begin tick(); n++; end
    chk("meta_out_valid", {63'd0, mo_tvalid}, 64'd1);
    tick();
    chk("meta_out_hold", {63'd0, mo_tvalid}, 64'd1);
    chk("meta_out_data", mo_tdata, exp);
    chk("meta_out_keep", {56'd0, mo_tkeep}, 64'hFF);
    chk("meta_out_last", {63'd0, mo_tlast}, 64'd1);
    mo_tready = 1'b1;
    tick();
    mo_tready = 1'b0;
  endtask

  task automatic recv_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input bit stall);
    int n = 0;
    do_tready = stall ? 1'b0 : 1'b1;
    while (do_tvalid !== 1'b1 && n < 40) begin tick(); n++; end
    chk("data_out_valid", {63'd0, do_tvalid}, 64'd1);
    if (stall) begin
      tick();
      chk("data_out_hold", {63'd0, do_tvalid}, 64'd1);
      do_tready = 1'b1;
    end
    chk("data_out_data", do_tdata, d);
    chk("data_out_keep", {56'd0, do_tkeep}, {56'd0, k});
    chk("data_out_last", {63'd0, do_tlast}, {63'd0, l});
    tick();
  endtask

  task automatic run_pkt(input logic [63:0] m, input logic [63:0] exp_m, input int nb, input bit stall);
    send_meta(m);
    for (int i = 0; i < nb; i++) send_beat(pkt_d[i], pkt_k[i], i == nb - 1);
    recv_meta(exp_m);
    for (int i = 0; i < nb; i++) recv_beat(pkt_d[i], pkt_k[i], i == nb - 1, stall);
    do_tready = 1'b0;
    chk("no_extra_beat", {63'd0, do_tvalid}, 64'd0);
    chk("state_idle_after_echo", {61'd0, dbg_state}, 64'd0);
  endtask

  task automatic fill(input logic [15:0] seed, input int nb, input logic [7:0] k);
    for (int i = 0; i < nb; i++) begin
      pkt_d[i] = {seed, 16'hC0DE, 16'h0000, 16'(i)} ^ {32'h0, 32'(i * 32'h01010101)};
      pkt_k[i] = k;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_meta_in_ready", {63'd0, mi_tready}, 64'd0);
    chk("rst_data_in_ready", {63'd0, di_tready}, 64'd0);
    chk("rst_meta_out_valid", {63'd0, mo_tvalid}, 64'd0);
    chk("rst_data_out_valid", {63'd0, do_tvalid}, 64'd0);
    chk("rst_meta_out_data", mo_tdata, 64'd0);
    chk("rst_data_out_data", do_tdata, 64'd0);
    chk("rst_pkt_cnt", {32'd0, pkt_cnt}, 64'd0);
    chk("rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
    chk("rd_reg_version", {48'd0, rd_reg}, 64'h0001);
    chk("rx_ports_disabled", {32'd0, rx_ports}, 64'd0);
    en = 1'b1;
    #1;
    chk("rx_ports_enabled", {32'd0, rx_ports}, 64'd1);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("sync_ready_edge1", {63'd0, mi_tready}, 64'd0);
    tick();
    chk("sync_ready_edge2", {63'd0, mi_tready}, 64'd1);

    // Reference echo: 3 beats, keeps FF FF 0F -> 20 bytes
    fill(16'h0001, 3, 8'hFF);
    pkt_k[2] = 8'h0F;
    run_pkt(64'h0010_0201_1234_0A7A, 64'h0014_0102_0A7A_1234, 3, 1'b0);
    chk("pkt_cnt_1", {32'd0, pkt_cnt}, 64'd1);

    // Zero-keep beat is carried but adds no bytes: 8+0+4+1 = 13
    fill(16'h0002, 4, 8'hFF);
    pkt_k[1] = 8'h00;
    pkt_k[2] = 8'h3C;
    pkt_k[3] = 8'h01;
    run_pkt(64'h0000_0A0B_5555_0A7A, 64'h000D_0B0A_0A7A_5555, 4, 1'b0);
    chk("pkt_cnt_2", {32'd0, pkt_cnt}, 64'd2);

    // Full-buffer packet under alternating output backpressure: 64 bytes
    fill(16'h0003, 8, 8'hFF);
    run_pkt(64'h0040_0504_BEEF_0A7A, 64'h0040_0405_0A7A_BEEF, 8, 1'b1);
    chk("pkt_cnt_3", {32'd0, pkt_cnt}, 64'd3);

    // Overflow: 10 beats into an 8-deep buffer are dropped silently
    send_meta(64'h0000_0102_3333_0A7A);
    for (int i = 0; i < 10; i++) begin
      send_beat(64'hDEAD_0000_0000_0000 | 64'(i), 8'hFF, i == 9);
      chk("drop_no_meta_out", {63'd0, mo_tvalid}, 64'd0);
    end
    chk("drop_no_data_out", {63'd0, do_tvalid}, 64'd0);
    chk("drop_cnt_1", {48'd0, drop_cnt}, 64'd1);
    chk("drop_pkt_cnt_same", {32'd0, pkt_cnt}, 64'd3);
    chk("drop_state_idle", {61'd0, dbg_state}, 64'd0);

    fill(16'h0004, 2, 8'hFF);
    pkt_k[1] = 8'h80;
    run_pkt(64'h0000_0302_00AA_0A7A, 64'h0009_0203_0A7A_00AA, 2, 1'b0);
    chk("pkt_cnt_after_drop", {32'd0, pkt_cnt}, 64'd4);

    // Data arriving before meta must stall
    di_tvalid = 1'b1;
    di_tdata = 64'h1234_5678_9ABC_DEF0;
    tick();
    tick();
    chk("early_data_stalled", {63'd0, di_tready}, 64'd0);
    chk("early_data_state", {61'd0, dbg_state}, 64'd0);
    di_tvalid = 1'b0;

    // Disabled role refuses meta; re-enabling accepts it on the next edge
    en = 1'b0;
    mi_tdata = 64'h0000_0706_0123_0A7A;
    mi_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("disabled_meta_ready", {63'd0, mi_tready}, 64'd0);
      chk("disabled_rx_ports", {32'd0, rx_ports}, 64'd0);
    end
    en = 1'b1;
    #1;
    chk("reenabled_meta_ready", {63'd0, mi_tready}, 64'd1);
    fill(16'h0005, 1, 8'h03);
    run_pkt(64'h0000_0706_0123_0A7A, 64'h0002_0607_0A7A_0123, 1, 1'b0);
    chk("pkt_cnt_5", {32'd0, pkt_cnt}, 64'd5);

    // Soft reset abandons a packet mid-receive and clears counters
    send_meta(64'h0000_0909_2222_0A7A);
    send_beat(64'h5555_5555_5555_5555, 8'hFF, 1'b0);
    soft_rst = 1'b1;
    tick();
    chk("soft_pkt_cnt", {32'd0, pkt_cnt}, 64'd0);
    chk("soft_drop_cnt", {48'd0, drop_cnt}, 64'd0);
    chk("soft_state", {61'd0, dbg_state}, 64'd0);
    chk("soft_data_ready", {63'd0, di_tready}, 64'd0);
    soft_rst = 1'b0;
    #1;
    chk("soft_meta_ready_after", {63'd0, mi_tready}, 64'd1);
    fill(16'h0006, 1, 8'hFF);
    run_pkt(64'h0000_0101_0F0F_0A7A, 64'h0008_0101_0A7A_0F0F, 1, 1'b0);
    chk("pkt_cnt_after_soft", {32'd0, pkt_cnt}, 64'd1);

    // Asynchronous reset while beat 2 of 5 is being presented
    fill(16'h0007, 5, 8'hFF);
    send_meta(64'h0000_0908_4444_0A7A);
    for (int i = 0; i < 5; i++) send_beat(pkt_d[i], pkt_k[i], i == 4);
    recv_meta(64'h0028_0809_0A7A_4444);
    recv_beat(pkt_d[0], pkt_k[0], 1'b0, 1'b0);
    recv_beat(pkt_d[1], pkt_k[1], 1'b0, 1'b0);
    do_tready = 1'b0;
    chk("beat2_presented", do_tdata, pkt_d[2]);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data_valid", {63'd0, do_tvalid}, 64'd0);
    chk("arst_data_out", do_tdata, 64'd0);
    chk("arst_meta_valid", {63'd0, mo_tvalid}, 64'd0);
    chk("arst_meta_ready", {63'd0, mi_tready}, 64'd0);
    chk("arst_data_ready", {63'd0, di_tready}, 64'd0);
    chk("arst_pkt_cnt", {32'd0, pkt_cnt}, 64'd0);
    chk("arst_state", {61'd0, dbg_state}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    fill(16'h0008, 2, 8'h0F);
    pkt_k[1] = 8'hF0;
    run_pkt(64'h0000_0C0D_7777_0A7A, 64'h0008_0D0C_0A7A_7777, 2, 1'b0);
    chk("pkt_cnt_after_arst", {32'd0, pkt_cnt}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
